// File: rtl/bft_pkg.sv
// bft_pkg: packet-format helpers and field positions shared by the BFT leaf port
// Packet layout is {valid, dest, payload}; defaults describe a 256-leaf network.
package bft_pkg;
    localparam int NUM_LEAVES = 256;
    localparam int PAYLOAD_SZ = 23;
    function automatic int dest_w(input int num_leaves);
        return $clog2(num_leaves);
    endfunction
    function automatic int p_sz(input int num_leaves, input int payload_sz);
        return 1 + dest_w(num_leaves) + payload_sz;
    endfunction
    localparam int P_SZ      = p_sz(NUM_LEAVES, PAYLOAD_SZ);
    localparam int VALID_BIT = P_SZ - 1;
    localparam int DEST_LSB  = PAYLOAD_SZ;
endpackage

// File: rtl/pe_sync_fifo.sv
// pe_sync_fifo: power-of-two synchronous FIFO with occupancy count
// Ports: clk, reset (async active-low), push/din write, pop/dout read (dout is
// a combinational view of the head), full, empty, level (occupancy).
// The caller gates push/pop; push while full is legal only together with pop.
module pe_sync_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [width-1:0]        din,
    output logic [width-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(depth):0]  level
);
    localparam int aw = $clog2(depth);
    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wp, rp;
    logic [aw:0]      cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + aw'(1);
            if (pop) rp <= rp + aw'(1);
            if (push != pop) cnt <= push ? cnt + (aw+1)'(1) : cnt - (aw+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end
    // depth is a power of two, so the count MSB alone means "full"
    assign dout  = mem[rp];
    assign full  = cnt[aw];
    assign empty = (cnt == '0);
    assign level = cnt;
endmodule

// File: rtl/pe_leaf_port.sv
// pe_leaf_port: PE-side port of a BFT leaf with TX queue, output register and RX queue
// Ports: clk, reset (async active-low); pe_interface/interface_pe network packets
// {valid,dest,payload}; resend holds the output packet; tx_data/tx_valid/tx_ready
// PE push side; rx_data/rx_valid/rx_ready PE drain side; tx_level TX occupancy;
// rx_drop_cnt saturating drop counter, present only when PE_DROP_CNT_EN is defined.
module pe_leaf_port
    import bft_pkg::*;
#(
    parameter int num_leaves = 256,
    parameter int payload_sz = 23,
    parameter int p_sz       = bft_pkg::p_sz(num_leaves, payload_sz),
    parameter int fifo_depth = 4,
    parameter int cnt_w      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [p_sz-1:0]              pe_interface,
    input  logic [p_sz-1:0]              interface_pe,
    input  logic                         resend,
    input  logic [p_sz-2:0]              tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [p_sz-2:0]              rx_data,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    output logic [$clog2(fifo_depth):0]  tx_level
`ifdef PE_DROP_CNT_EN
    ,
    output logic [cnt_w-1:0]             rx_drop_cnt
`endif
);
    logic [p_sz-2:0]             tx_head;
    logic                        tx_full, tx_empty, tx_push, tx_pop, out_load;
    logic                        rx_full, rx_empty, rx_push, rx_pop;
    logic [$clog2(fifo_depth):0] unused_rx_level;
    // the output stage may take a new packet when it is empty or being accepted
    always_comb begin
        out_load = !pe_interface[p_sz-1] || !resend;
        tx_ready = !tx_full;
        tx_push  = tx_valid && !tx_full;
        tx_pop   = out_load && !tx_empty;
        rx_valid = !rx_empty;
        rx_pop   = !rx_empty && rx_ready;
        rx_push  = interface_pe[p_sz-1] && (!rx_full || rx_pop);
    end
    pe_sync_fifo #(.width(p_sz-1), .depth(fifo_depth)) u_tx (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(tx_data),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );
    pe_sync_fifo #(.width(p_sz-1), .depth(fifo_depth)) u_rx (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(interface_pe[p_sz-2:0]),
        .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(unused_rx_level)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pe_interface <= '0;
        else if (out_load) pe_interface <= tx_empty ? '0 : {1'b1, tx_head};
    end
`ifdef PE_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_drop_cnt <= '0;
        else if (interface_pe[p_sz-1] && !rx_push && rx_drop_cnt != '1) rx_drop_cnt <= rx_drop_cnt + cnt_w'(1);
    end
`endif
endmodule

// File: tb/tb_pe_leaf_port.sv
// tb_pe_leaf_port: vector table, directed corner sequences and queue-model random test
module tb_pe_leaf_port;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] pe_interface, interface_pe;
    logic        resend, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [30:0] tx_data, rx_data;
    logic [2:0]  tx_level;
`ifdef PE_DROP_CNT_EN
    logic [15:0] rx_drop_cnt;
`endif
    int checks = 0;
    int errors = 0;
    logic [30:0] tq[$];
    logic [30:0] rq[$];
    logic [31:0] m_out;
    int          m_drop;

    pe_leaf_port dut (
        .clk(clk), .reset(rst_n), .pe_interface(pe_interface), .interface_pe(interface_pe),
        .resend(resend), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_level(tx_level)
`ifdef PE_DROP_CNT_EN
        , .rx_drop_cnt(rx_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [30:0] td;
        logic        rs;
        logic [31:0] ip;
        logic        rr;
        logic [31:0] e_pe;
        logic        e_rdy;
        logic [2:0]  e_lvl;
        logic        e_rxv;
        logic [30:0] e_rxd;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tx_valid = 0;
        tx_data = '0;
        resend = 0;
        interface_pe = '0;
        rx_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic chk_drop(input int e);
`ifdef PE_DROP_CNT_EN
        chk("drop_cnt", 32'(rx_drop_cnt), 32'(e));
`endif
    endtask

    task automatic model_step();
        bit rdy   = tq.size() < 4;
        bit rpop  = rq.size() > 0 && rx_ready;
        bit rfull = rq.size() == 4;
        if (!m_out[31] || !resend) begin
            if (tq.size() > 0) m_out = {1'b1, tq.pop_front()};
            else m_out = 32'h0;
        end
        if (tx_valid && rdy) tq.push_back(tx_data);
        if (rpop) void'(rq.pop_front());
        if (interface_pe[31]) begin
            if (!rfull || rpop) rq.push_back(interface_pe[30:0]);
            else if (m_drop < 65535) m_drop++;
        end
    endtask

    initial begin
        int acc;
        bit took;
        tbl[0]  = '{1, 31'h02800ABC, 0, 32'h0,        0, 32'h0,        1, 3'd1, 0, 31'h0};
        tbl[1]  = '{0, 31'h0,        0, 32'h0,        0, 32'h82800ABC, 1, 3'd0, 0, 31'h0};
        tbl[2]  = '{0, 31'h0,        0, 32'h0,        0, 32'h0,        1, 3'd0, 0, 31'h0};
        tbl[3]  = '{1, 31'h02800ABC, 0, 32'h0,        0, 32'h0,        1, 3'd1, 0, 31'h0};
        tbl[4]  = '{1, 31'h03000001, 0, 32'h0,        0, 32'h82800ABC, 1, 3'd1, 0, 31'h0};
        tbl[5]  = '{0, 31'h0,        1, 32'h0,        0, 32'h82800ABC, 1, 3'd1, 0, 31'h0};
        tbl[6]  = '{0, 31'h0,        1, 32'h0,        0, 32'h82800ABC, 1, 3'd1, 0, 31'h0};
        tbl[7]  = '{0, 31'h0,        1, 32'h0,        0, 32'h82800ABC, 1, 3'd1, 0, 31'h0};
        tbl[8]  = '{0, 31'h0,        0, 32'h0,        0, 32'h83000001, 1, 3'd0, 0, 31'h0};
        tbl[9]  = '{0, 31'h0,        0, 32'h0,        0, 32'h0,        1, 3'd0, 0, 31'h0};
        tbl[10] = '{0, 31'h0,        0, 32'h80000007, 0, 32'h0,        1, 3'd0, 1, 31'h7};
        tbl[11] = '{0, 31'h0,        0, 32'h0,        1, 32'h0,        1, 3'd0, 0, 31'h0};
        tbl[12] = '{1, 31'h7FFFFFFF, 1, 32'h0,        0, 32'h0,        1, 3'd1, 0, 31'h0};
        tbl[13] = '{0, 31'h0,        1, 32'h0,        0, 32'hFFFFFFFF, 1, 3'd0, 0, 31'h0};
        tbl[14] = '{0, 31'h0,        0, 32'h0,        0, 32'h0,        1, 3'd0, 0, 31'h0};

        do_reset();
        chk("rst_pe", pe_interface, 32'h0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_tx_level", 32'(tx_level), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk_drop(0);

        for (int i = 0; i < 15; i++) begin
            tx_valid = tbl[i].tv;
            tx_data = tbl[i].td;
            resend = tbl[i].rs;
            interface_pe = tbl[i].ip;
            rx_ready = tbl[i].rr;
            step();
            chk($sformatf("vec%0d_pe", i), pe_interface, tbl[i].e_pe);
            chk($sformatf("vec%0d_rdy", i), 32'(tx_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_lvl", i), 32'(tx_level), 32'(tbl[i].e_lvl));
            chk($sformatf("vec%0d_rxv", i), 32'(rx_valid), 32'(tbl[i].e_rxv));
            if (tbl[i].e_rxv) chk($sformatf("vec%0d_rxd", i), 32'(rx_data), 32'(tbl[i].e_rxd));
        end

        do_reset();
        resend = 1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            tx_valid = 1;
            tx_data = 31'h100 + 31'(acc);
            took = tx_ready;
            step();
            if (took) acc++;
        end
        chk("cap_accepted", 32'(acc), 32'd5);
        chk("cap_tx_ready", 32'(tx_ready), 32'd0);
        chk("cap_tx_level", 32'(tx_level), 32'd4);
        chk("cap_pe_held", pe_interface, 32'h80000100);
        tx_valid = 0;
        resend = 0;
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("cap_out%0d", k), pe_interface, 32'h80000100 + 32'(k));
        end
        step();
        chk("cap_out_end", pe_interface, 32'h0);

        do_reset();
        for (int i = 1; i <= 6; i++) begin
            interface_pe = 32'h80000000 + 32'(i);
            step();
        end
        interface_pe = 0;
        chk("rxov_valid", 32'(rx_valid), 32'd1);
        chk_drop(2);
        rx_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("rxov_data%0d", i), 32'(rx_data), 32'(i));
            step();
        end
        chk("rxov_empty", 32'(rx_valid), 32'd0);
        rx_ready = 0;

        for (int i = 0; i < 4; i++) begin
            interface_pe = 32'h80000011 + 32'(i);
            step();
        end
        interface_pe = 32'h80000015;
        rx_ready = 1;
        step();
        interface_pe = 0;
        rx_ready = 0;
        chk("rxfull_head", 32'(rx_data), 32'h12);
        chk_drop(2);
        rx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rxfull_data%0d", i), 32'(rx_data), 32'h12 + 32'(i));
            step();
        end
        chk("rxfull_empty", 32'(rx_valid), 32'd0);
        rx_ready = 0;

        tx_valid = 1;
        tx_data = 31'h55;
        step();
        tx_data = 31'h56;
        resend = 1;
        interface_pe = 32'h80000033;
        step();
        tx_valid = 0;
        interface_pe = 0;
        step();
        chk("ar_pre_pe", pe_interface, 32'h80000055);
        chk("ar_pre_rxv", 32'(rx_valid), 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("ar_pe", pe_interface, 32'h0);
        chk("ar_rxv", 32'(rx_valid), 32'd0);
        chk("ar_tx_ready", 32'(tx_ready), 32'd1);
        chk("ar_tx_level", 32'(tx_level), 32'd0);
        idle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        tx_valid = 1;
        tx_data = 31'h02800ABC;
        step();
        chk("ar_e0_pe", pe_interface, 32'h0);
        tx_valid = 0;
        step();
        chk("ar_e1_pe", pe_interface, 32'h82800ABC);
        step();
        chk("ar_e2_pe", pe_interface, 32'h0);

        do_reset();
        tq.delete();
        rq.delete();
        m_out = 0;
        m_drop = 0;
        for (int c = 0; c < 400; c++) begin
            tx_valid = $urandom_range(3) != 0;
            tx_data = 31'($urandom());
            resend = $urandom_range(1) != 0;
            interface_pe = {1'($urandom_range(1)), 31'($urandom())};
            rx_ready = $urandom_range(1) != 0;
            model_step();
            step();
            chk("rnd_pe", pe_interface, m_out);
            chk("rnd_tx_ready", 32'(tx_ready), 32'(tq.size() < 4));
            chk("rnd_tx_level", 32'(tx_level), 32'(tq.size()));
            chk("rnd_rx_valid", 32'(rx_valid), 32'(rq.size() > 0));
            if (rq.size() > 0) chk("rnd_rx_data", 32'(rx_data), 32'(rq[0]));
            chk_drop(m_drop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
